// File: rtl/demux8_collector_if.sv
// Bit-in / word-out bus of the 8-bit demux collector.
// Handshake: a transfer happens on a rising edge where valid && ready; valid/data must hold until then.
interface demux8_collector_if;
  logic       din;
  logic [2:0] sel;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       dup_err;
  logic [1:0] state_dbg;

  modport slave (
    input  din, sel, mode, in_valid, out_ready,
    output in_ready, out, out_valid, dup_err, state_dbg
  );

  modport master (
    output din, sel, mode, in_valid, out_ready,
    input  in_ready, out, out_valid, dup_err, state_dbg
  );
endinterface

// File: rtl/demux8_collector.sv
// Collects single bits into an 8-bit word, either by explicit position (sel)
// or by an internal up/down counter, and hands the word out over valid/ready.
module demux8_collector #(
  parameter bit LSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  demux8_collector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [2:0] CNT_START = LSB_FIRST ? 3'd0 : 3'd7;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic       dup_q, dup_d;

  logic       out_valid;
  logic       accept;
  logic       handshake;
  logic       new_word;
  logic       mode_eff;
  logic [7:0] mask_base;
  logic [2:0] cnt_base;
  logic [2:0] pos;

  assign out_valid     = (state_q == FULL);
  assign bus.in_ready  = !out_valid || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign handshake     = out_valid && bus.out_ready;
  assign bus.out       = data_q;
  assign bus.out_valid = out_valid;
  assign bus.dup_err   = dup_q;
  assign bus.state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dup_d   = 1'b0;

    // A bit accepted outside FILL starts a fresh word: in FULL it can only be
    // accepted alongside the output handshake, which releases the old word.
    new_word  = (state_q != FILL);
    mode_eff  = new_word ? bus.mode : mode_q;
    mask_base = new_word ? 8'h00 : mask_q;
    cnt_base  = new_word ? CNT_START : cnt_q;
    pos       = mode_eff ? cnt_base : bus.sel;

    if (accept) begin
      data_d[pos] = bus.din;
      mask_d      = mask_base | (8'h01 << pos);
      mode_d      = mode_eff;
      dup_d       = !mode_eff && mask_base[pos];
      if (mode_eff) begin
        cnt_d = LSB_FIRST ? (cnt_base + 3'd1) : (cnt_base - 3'd1);
      end else begin
        cnt_d = cnt_base;
      end
      state_d = (mask_d == 8'hFF) ? FULL : FILL;
    end else if (handshake) begin
      state_d = IDLE;
      mask_d  = 8'h00;
      cnt_d   = CNT_START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      mask_q  <= 8'h00;
      cnt_q   <= CNT_START;
      mode_q  <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dup_q   <= dup_d;
    end
  end

endmodule

// File: tb/tb_demux8_collector.sv
// Directed bench for demux8_collector: a vector table of single-cycle steps
// plus hand-written reset and MSB-first sequences.
module tb_demux8_collector;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic clk;
  logic rst;
  logic rst1;

  demux8_collector_if bus0 ();
  demux8_collector_if bus1 ();

  demux8_collector #(.LSB_FIRST(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus0));
  demux8_collector #(.LSB_FIRST(1'b0)) dut_msb (.clk(clk), .rst(rst1), .bus(bus1));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       iv;
    logic       din;
    logic [2:0] sel;
    logic       mode;
    logic       ordy;
    logic       chk_ir;
    logic       e_ir;
    logic       chk_out;
    logic [7:0] e_out;
    logic       e_ov;
    logic       e_dup;
    logic [1:0] e_st;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic iv, logic din, logic [2:0] sel, logic mode,
                              logic ordy, logic chk_ir, logic e_ir, logic chk_out,
                              logic [7:0] e_out, logic e_ov, logic e_dup, logic [1:0] e_st);
    vec_t v;
    v.rst = r; v.iv = iv; v.din = din; v.sel = sel; v.mode = mode; v.ordy = ordy;
    v.chk_ir = chk_ir; v.e_ir = e_ir; v.chk_out = chk_out; v.e_out = e_out;
    v.e_ov = e_ov; v.e_dup = e_dup; v.e_st = e_st;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: drive on the falling edge, check in_ready before the rising edge
  // and the registered outputs just after it
  task automatic step(string tag, vec_t v);
    @(negedge clk);
    rst            = v.rst;
    bus0.in_valid  = v.iv;
    bus0.din       = v.din;
    bus0.sel       = v.sel;
    bus0.mode      = v.mode;
    bus0.out_ready = v.ordy;
    #1;
    if (v.chk_ir) check({tag, " in_ready"}, {7'd0, bus0.in_ready}, {7'd0, v.e_ir});
    @(posedge clk);
    #1;
    if (v.chk_out) check({tag, " out"}, bus0.out, v.e_out);
    check({tag, " out_valid"}, {7'd0, bus0.out_valid}, {7'd0, v.e_ov});
    check({tag, " dup_err"}, {7'd0, bus0.dup_err}, {7'd0, v.e_dup});
    check({tag, " state"}, {6'd0, bus0.state_dbg}, {6'd0, v.e_st});
  endtask

  initial begin : main
    logic [7:0] seq_bits;
    logic [2:0] a_sel[8];
    logic       a_din[8];
    logic [2:0] d_sel[9];
    logic       d_din[9];
    logic       d_dup[9];
    logic       m_din[8];
    logic [7:0] fresh;

    rst = 1'b1;
    rst1 = 1'b1;
    bus0.in_valid = 1'b0; bus0.din = 1'b0; bus0.sel = 3'd0; bus0.mode = 1'b0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.din = 1'b0; bus1.sel = 3'd0; bus1.mode = 1'b0; bus1.out_ready = 1'b0;

    // reset state
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0, S_IDLE));

    // sequential LSB-first word 1,0,1,1,0,0,1,0 -> 8'h4D
    seq_bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, seq_bits[i], 0, 1, 1, 1, 1, (i == 7), 8'h4D,
                       (i == 7), 0, (i == 7) ? S_FULL : S_FILL));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, S_IDLE));

    // addressed word, sel 7..0 -> 8'hC3
    a_sel = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    a_din = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, a_din[i], a_sel[i], 0, 0, 1, 1, (i == 7), 8'hC3,
                       (i == 7), 0, (i == 7) ? S_FULL : S_FILL));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, S_IDLE));

    // addressed word with a duplicate write to position 3; needs all 8 positions -> 8'hA5
    d_sel = '{3'd3, 3'd3, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd7};
    d_din = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    d_dup = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(0, 1, d_din[i], d_sel[i], 0, 0, 1, 1, (i == 8), 8'hA5,
                       (i == 8), d_dup[i], (i == 8) ? S_FULL : S_FILL));

    // backpressure: word held, bits offered but refused
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 8'hA5, 1, 0, S_FULL));

    // handshake and first bit of next word in the same cycle (sequential)
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1, 1, 0, 8'h00, 0, 0, S_FILL));
    // two more sequential bits, then mode input drops to addressed with sel=0
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 8'h00, 0, 0, S_FILL));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 8'h00, 0, 0, S_FILL));
    seq_bits = 8'b0110_0101;
    for (int i = 3; i < 8; i++)
      tbl.push_back(mk(0, 1, seq_bits[i], 0, 0, 0, 1, 1, (i == 7), 8'h65,
                       (i == 7), 0, (i == 7) ? S_FULL : S_FILL));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, S_IDLE));

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i]);

    // reset after 5 bits discards the partial word
    for (int i = 0; i < 5; i++)
      step($sformatf("pre_rst%0d", i), mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 8'h00, 0, 0, S_FILL));
    step("rst_mid", mk(1, 1, 1, 0, 1, 1, 1, 1, 1, 8'h00, 0, 0, S_IDLE));
    fresh = 8'b1010_0110;
    for (int i = 0; i < 8; i++)
      step($sformatf("fresh%0d", i), mk(0, 1, fresh[i], 0, 1, 0, 1, 1, (i == 7), 8'hA6,
                                        (i == 7), 0, (i == 7) ? S_FULL : S_FILL));
    // reset wins over a held full word
    step("rst_full", mk(1, 1, 1, 0, 1, 0, 1, 0, 1, 8'h00, 0, 0, S_IDLE));
    step("post_rst", mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h00, 0, 0, S_IDLE));

    // MSB-first instance: same bits as 8'h4D fill from position 7 down -> 8'hB2
    m_din = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    rst1 = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.mode = 1'b1;
    bus1.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus1.din = m_din[i];
      bus1.sel = 3'(i);
      @(posedge clk);
      #1;
      check($sformatf("msb%0d out_valid", i), {7'd0, bus1.out_valid}, {7'd0, (i == 7)});
      @(negedge clk);
    end
    check("msb out", bus1.out, 8'hB2);
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("msb release", {7'd0, bus1.out_valid}, 8'h00);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux8_collector.md
DEMUX8_COLLECTOR -- requirements
Module: demux8_collector

Interface
REQ-001 Parameter: LSB_FIRST, default 1, sequential-mode fill order (1: position 0 first; 0: position 7 first).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: din  input  1  data bit to be steered into the word.
REQ-005 Port: sel  input  3  target bit position, used in addressed mode only.
REQ-006 Port: mode  input  1  0 = addressed (position = sel), 1 = sequential (position = internal counter).
REQ-007 Port: in_valid  input  1  din/sel/mode valid this cycle.
REQ-008 Port: in_ready  output  1  block accepts a bit this cycle; a bit is accepted when in_valid && in_ready.
REQ-009 Port: out  output  8  assembled word.
REQ-010 Port: out_valid  output  1  out holds a complete word.
REQ-011 Port: out_ready  input  1  consumer takes the word; handshake completes when out_valid && out_ready.
REQ-012 Port: dup_err  output  1  one-cycle pulse: addressed write hit an already-filled position.

Function
REQ-013 The block SHALL hold an 8-bit data register, an 8-bit fill mask, a 3-bit position counter, a latched mode bit and a state in {IDLE, FILL, FULL}.
REQ-014 IDLE: mask = 0; the first accepted bit latches mode and moves to FILL (or to FULL if it completes the word, impossible except via REQ-020 rules, i.e. never in one bit).
REQ-015 FILL: each accepted bit writes data[pos] = din and sets mask[pos]; when mask becomes 8'hFF, the next state is FULL.
REQ-016 FULL: out_valid = 1, out = data; remains in FULL until the output handshake.
REQ-017 Mode is latched at the first bit of each word; changes of the mode input mid-word SHALL be ignored until the next word.
REQ-018 Sequential mode: pos = counter; counter starts at 0 (LSB_FIRST=1) or 7 (LSB_FIRST=0) per word and steps by +1/-1 per accepted bit; sel ignored.
REQ-019 Addressed mode: pos = sel; a write to a position whose mask bit is set SHALL overwrite data[pos], leave mask unchanged, and pulse dup_err high for the following cycle.
REQ-020 in_ready = !out_valid || out_ready (combinational); no bit is accepted in FULL without a same-cycle handshake.
REQ-021 Simultaneous output handshake and accepted bit: the word is released, mask/counter restart, and the accepted bit becomes the first bit of the new word (state FILL, mode re-latched).
REQ-022 Handshake without accepted bit: state returns to IDLE, mask cleared, out_valid low next cycle.
REQ-023 Latency: word-completing bit accepted at edge N -> out_valid = 1 after edge N, out stable until handshake.
REQ-024 out SHALL present data continuously; its value is meaningful only while out_valid = 1.
REQ-025 dup_err SHALL never be asserted in sequential mode.

Reset
REQ-026 rst sampled high at a rising edge SHALL set state IDLE, data = 8'h00, mask = 8'h00, counter per LSB_FIRST, latched mode 0, out = 8'h00, out_valid = 0, dup_err = 0.
REQ-027 Reset SHALL take precedence over any same-cycle input or handshake; a partially filled or unconsumed word is discarded.
REQ-028 During and after reset in_ready = 1.

Verification
REQ-029 Sequential, LSB_FIRST=1, din = 1,0,1,1,0,0,1,0 on 8 consecutive cycles, out_ready=1 -> out = 8'h4D, out_valid high exactly one cycle after 8th bit.
REQ-030 Addressed, sel = 7,6,...,0 with din = 1,1,0,0,0,0,1,1 -> out = 8'hC3; then sel=3 written twice in next word -> dup_err one-cycle pulse, mask unchanged.
REQ-031 Backpressure: word 8'hA5 complete, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out stable 8'hA5, no bits lost; out_ready=1 -> handshake, in_ready=1.
REQ-032 Simultaneous handshake + bit: out_valid=1, out_ready=1, in_valid=1 din=1 sequential -> next word data[0]=1, state FILL, out_valid=0.
REQ-033 Mode toggled after 3 sequential bits -> remainder still sequential, word completes after 8 bits total.
REQ-034 rst asserted after 5 bits -> all outputs zero next cycle; following 8 bits form a fresh word with no residue.
